mem_wb_stage: RTL and testbench

Parametrised MEM/WB pipeline stage for the pipelined MIPS core, replacing the fixed 16-bit MEM/WB register. It carries one write-back beat per cycle through a 2-entry elastic buffer with valid/ready handshakes, a synchronous flush and a registered input-ready. It resolves the write-back source at load time and exports forwarding data for hazard units in EX/MEM.

---
 rtl/mem_wb_stage.sv | 184 ++++++++++++++++++
 tb/tb_mem_wb_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: 2-entry elastic buffer (head + skid) with valid/ready,
// synchronous flush, registered in_ready and write-back source resolved at load.
module mem_wb_stage #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 10,   // DATA_W >= PC_W required
    parameter int REG_AW = 4
) (
    input  logic              Clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic              wb_en_in,
    input  logic [1:0]        wb_sel_in,
    input  logic [PC_W-1:0]   pc_in,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [DATA_W-1:0] mem_in,
    input  logic [REG_AW-1:0] dst_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              wb_en_out,
    output logic [DATA_W-1:0] wb_data_out,
    output logic [REG_AW-1:0] dst_out,
    output logic [PC_W-1:0]   pc_out,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_dst,
    output logic [DATA_W-1:0] fwd_data,
    output logic [1:0]        occ
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // PC+1 wraps at PC_W bits before being zero-extended into the data path
    function automatic logic [DATA_W-1:0] resolve_wb(
        input logic [1:0]        sel,
        input logic [PC_W-1:0]   pc,
        input logic [DATA_W-1:0] alu,
        input logic [DATA_W-1:0] mem
    );
        logic [PC_W-1:0]   pc_inc;
        logic [DATA_W-1:0] res;
        pc_inc = pc + {{(PC_W-1){1'b0}}, 1'b1};
        case (sel)
            2'b01:   res = mem;
            2'b10:   res = DATA_W'(pc_inc);
            default: res = alu;
        endcase
        return res;
    endfunction

    state_t              state_r, state_nxt_s;
    logic                in_ready_r, in_ready_nxt_s;
    logic                in_fire_s, out_fire_s;
    logic                load_head_in_s, load_head_skid_s, load_skid_s;
    logic [DATA_W-1:0]   in_data_s;
    logic                in_wen_s;

    logic [DATA_W-1:0]   head_data_r, skid_data_r;
    logic [REG_AW-1:0]   head_dst_r, skid_dst_r;
    logic [PC_W-1:0]     head_pc_r, skid_pc_r;
    logic                head_wen_r, skid_wen_r;

    assign in_fire_s  = in_valid & in_ready_r;
    assign out_fire_s = out_valid & out_ready;
    assign in_data_s  = resolve_wb(wb_sel_in, pc_in, alu_in, mem_in);
    // r0 is hard-wired, so a write to it is never enabled
    assign in_wen_s   = wb_en_in & (dst_in != {REG_AW{1'b0}});

    // State and in_ready registers
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_EMPTY;
            in_ready_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            in_ready_r <= in_ready_nxt_s;
        end
    end

    // Next-state, storage load strobes and next in_ready
    always_comb begin
        state_nxt_s      = state_r;
        load_head_in_s   = 1'b0;
        load_head_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        if (flush) begin
            state_nxt_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        state_nxt_s    = ST_ONE;
                        load_head_in_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (in_fire_s && out_fire_s) begin
                        load_head_in_s = 1'b1;
                    end else if (in_fire_s) begin
                        state_nxt_s = ST_TWO;
                        load_skid_s = 1'b1;
                    end else if (out_fire_s) begin
                        state_nxt_s = ST_EMPTY;
                    end else begin
                        state_nxt_s = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (out_fire_s) begin
                        state_nxt_s      = ST_ONE;
                        load_head_skid_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_TWO;
                    end
                end
                default: state_nxt_s = ST_EMPTY;
            endcase
        end
        in_ready_nxt_s = flush | (state_nxt_s != ST_TWO);
    end

    // Head entry: loaded from the input or promoted from the skid
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            head_data_r <= {DATA_W{1'b0}};
            head_dst_r  <= {REG_AW{1'b0}};
            head_pc_r   <= {PC_W{1'b0}};
            head_wen_r  <= 1'b0;
        end else if (flush) begin
            head_data_r <= {DATA_W{1'b0}};
            head_dst_r  <= {REG_AW{1'b0}};
            head_pc_r   <= {PC_W{1'b0}};
            head_wen_r  <= 1'b0;
        end else if (load_head_in_s) begin
            head_data_r <= in_data_s;
            head_dst_r  <= dst_in;
            head_pc_r   <= pc_in;
            head_wen_r  <= in_wen_s;
        end else if (load_head_skid_s) begin
            head_data_r <= skid_data_r;
            head_dst_r  <= skid_dst_r;
            head_pc_r   <= skid_pc_r;
            head_wen_r  <= skid_wen_r;
        end
    end

    // Skid entry: absorbs the beat that arrives while the head is stalled
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_data_r <= {DATA_W{1'b0}};
            skid_dst_r  <= {REG_AW{1'b0}};
            skid_pc_r   <= {PC_W{1'b0}};
            skid_wen_r  <= 1'b0;
        end else if (flush) begin
            skid_data_r <= {DATA_W{1'b0}};
            skid_dst_r  <= {REG_AW{1'b0}};
            skid_pc_r   <= {PC_W{1'b0}};
            skid_wen_r  <= 1'b0;
        end else if (load_skid_s) begin
            skid_data_r <= in_data_s;
            skid_dst_r  <= dst_in;
            skid_pc_r   <= pc_in;
            skid_wen_r  <= in_wen_s;
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = (state_r != ST_EMPTY);
    assign occ         = state_r;
    assign wb_en_out   = out_valid & head_wen_r;
    assign wb_data_out = head_data_r;
    assign dst_out     = head_dst_r;
    assign pc_out      = head_pc_r;
    assign fwd_valid   = wb_en_out;
    assign fwd_dst     = head_dst_r;
    assign fwd_data    = head_data_r;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_mem_wb_stage;

    localparam int DATA_W = 16;
    localparam int PC_W   = 10;
    localparam int REG_AW = 4;

    logic              Clk, rst_n;
    logic              in_valid, in_ready, flush, wb_en_in, out_valid, out_ready;
    logic [1:0]        wb_sel_in, occ;
    logic [PC_W-1:0]   pc_in, pc_out;
    logic [DATA_W-1:0] alu_in, mem_in, wb_data_out, fwd_data;
    logic [REG_AW-1:0] dst_in, dst_out, fwd_dst;
    logic              wb_en_out, fwd_valid;

    mem_wb_stage #(.DATA_W(DATA_W), .PC_W(PC_W), .REG_AW(REG_AW)) dut (
        .Clk(Clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .wb_en_in(wb_en_in), .wb_sel_in(wb_sel_in), .pc_in(pc_in),
        .alu_in(alu_in), .mem_in(mem_in), .dst_in(dst_in), .out_valid(out_valid),
        .out_ready(out_ready), .wb_en_out(wb_en_out), .wb_data_out(wb_data_out),
        .dst_out(dst_out), .pc_out(pc_out), .fwd_valid(fwd_valid), .fwd_dst(fwd_dst),
        .fwd_data(fwd_data), .occ(occ)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        int data;
        int dst;
        int pc;
        int wen;
    } beat_t;

    beat_t q[$];
    int    ir_m;
    int    n_run  = 0;
    int    n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_occ"}, 32'(occ), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_wb_en"}, 32'(wb_en_out), 32'd0);
        check({tag, "_fwd_valid"}, 32'(fwd_valid), 32'd0);
        check({tag, "_data"}, 32'(wb_data_out), 32'd0);
        check({tag, "_fwd_data"}, 32'(fwd_data), 32'd0);
        check({tag, "_dst"}, 32'(dst_out), 32'd0);
        check({tag, "_fwd_dst"}, 32'(fwd_dst), 32'd0);
        check({tag, "_pc"}, 32'(pc_out), 32'd0);
    endtask

    task automatic check_model();
        check("occ", 32'(occ), 32'(q.size()));
        check("out_valid", 32'(out_valid), 32'(q.size() != 0));
        check("in_ready", 32'(in_ready), 32'(ir_m));
        if (q.size() != 0) begin
            check("wb_data", 32'(wb_data_out), 32'(q[0].data));
            check("dst", 32'(dst_out), 32'(q[0].dst));
            check("pc", 32'(pc_out), 32'(q[0].pc));
            check("wb_en", 32'(wb_en_out), 32'(q[0].wen));
            check("fwd_valid", 32'(fwd_valid), 32'(q[0].wen));
            check("fwd_dst", 32'(fwd_dst), 32'(q[0].dst));
            check("fwd_data", 32'(fwd_data), 32'(q[0].data));
        end else begin
            check("wb_en_empty", 32'(wb_en_out), 32'd0);
            check("fwd_valid_empty", 32'(fwd_valid), 32'd0);
        end
    endtask

    // One clock cycle: drive inputs, predict with the queue model, compare after the edge
    task automatic cycle(input logic iv, input logic ordy, input logic fl, input logic en,
                         input logic [1:0] sel, input int pc, input int alu, input int mem,
                         input int dst);
        bit    in_fire, out_fire;
        beat_t b, popped;
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        wb_en_in  = en;
        wb_sel_in = sel;
        pc_in     = PC_W'(pc);
        alu_in    = DATA_W'(alu);
        mem_in    = DATA_W'(mem);
        dst_in    = REG_AW'(dst);
        in_fire   = iv && (ir_m != 0);
        out_fire  = (q.size() != 0) && ordy;
        case (sel)
            2'b01:   b.data = mem % (1 << DATA_W);
            2'b10:   b.data = (pc % (1 << PC_W) + 1) % (1 << PC_W);
            default: b.data = alu % (1 << DATA_W);
        endcase
        b.dst = dst % (1 << REG_AW);
        b.pc  = pc % (1 << PC_W);
        b.wen = (en && b.dst != 0) ? 1 : 0;
        @(posedge Clk);
        #1;
        if (out_fire) popped = q.pop_front();
        if (fl) begin
            q.delete();
            ir_m = 1;
        end else begin
            if (in_fire) q.push_back(b);
            ir_m = (q.size() < 2) ? 1 : 0;
        end
        check_model();
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, ordy, 1'b0, 1'b0, 2'b00, 0, 0, 0, 0);
    endtask

    task automatic scenario_first();
        // First edge after release only raises in_ready; the beat is taken on the second
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 16, 32'h1234, 0, 5);
        check("s1_in_ready", 32'(in_ready), 32'd1);
        check("s1_occ_before", 32'(occ), 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 16, 32'h1234, 0, 5);
        check("s1_out_valid", 32'(out_valid), 32'd1);
        check("s1_data", 32'(wb_data_out), 32'h1234);
        check("s1_dst", 32'(dst_out), 32'd5);
        check("s1_wb_en", 32'(wb_en_out), 32'd1);
        check("s1_occ", 32'(occ), 32'd1);
        idle(1'b1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        wb_en_in = 1'b0; wb_sel_in = 2'b00; pc_in = '0; alu_in = '0; mem_in = '0; dst_in = '0;
        ir_m = 0;
        #12;
        check_reset_vals("rst");
        @(negedge Clk);
        rst_n = 1'b1;

        scenario_first();

        // Source mux: memory data, then PC+1 wrapping to zero
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 7, 32'h1111, 32'hBEEF, 3);
        check("mux_mem", 32'(wb_data_out), 32'hBEEF);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 32'h3FF, 32'h2222, 32'h3333, 4);
        check("mux_pc_wrap", 32'(wb_data_out), 32'h0000);
        check("mux_pc_out", 32'(pc_out), 32'h3FF);
        idle(1'b1);

        // Backpressure: A, B absorbed, C held, then drained in order
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1, 32'hA, 0, 10);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2, 32'hB, 0, 11);
        check("bp_occ2", 32'(occ), 32'd2);
        check("bp_in_ready0", 32'(in_ready), 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 3, 32'hC, 0, 12);
        check("bp_head_a", 32'(dst_out), 32'd10);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 3, 32'hC, 0, 12);
        check("bp_head_b", 32'(dst_out), 32'd11);
        check("bp_in_ready1", 32'(in_ready), 32'd1);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 3, 32'hC, 0, 12);
        check("bp_head_c", 32'(dst_out), 32'd12);
        idle(1'b1);

        // r0 destination never enables a write
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 5, 32'h5555, 0, 0);
        check("r0_valid", 32'(out_valid), 32'd1);
        check("r0_wb_en", 32'(wb_en_out), 32'd0);
        check("r0_fwd_valid", 32'(fwd_valid), 32'd0);
        idle(1'b1);

        // Flush with both entries held and a beat on the input
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 8, 32'h88, 0, 8);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 9, 32'h99, 0, 9);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 6, 32'h66, 0, 6);
        check("fl_occ", 32'(occ), 32'd0);
        check("fl_out_valid", 32'(out_valid), 32'd0);
        check("fl_in_ready", 32'(in_ready), 32'd1);
        idle(1'b1);
        idle(1'b1);

        // Asynchronous reset with two beats held
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 8, 32'h88, 0, 8);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 9, 32'h99, 0, 9);
        check("mr_occ2", 32'(occ), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        q.delete();
        ir_m = 0;
        in_valid = 1'b0;
        @(negedge Clk);
        rst_n = 1'b1;
        scenario_first();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), int'($urandom_range(0, 1023)),
                  int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                  int'($urandom_range(0, 15)));
        end
        for (int i = 0; i < 3; i++) idle(1'b1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
